if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the program counter, drives the instruction-memory address and latches the IF/ID pipeline register.
- The IF/ID instruction field feeds the ID stage. Its opcode bits [31:26] go to the main decoder.
- Accepts stall from the hazard-detection unit and redirect (branch/jump) from ID. Flushes the wrong-path instruction on redirect.

---
 rtl/if_stage.sv | 68 ++++++
 tb/tb_if_stage.sv | 124 ++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: MIPS instruction-fetch stage owning the PC and the IF/ID register, with stall, redirect and flush.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             stall_i,
   input  logic             branch_taken_i,
   input  logic [31:0]      branch_addr_i,
   input  logic             jump_i,
   input  logic [31:0]      jump_addr_i,
   output logic [31:0]      imem_addr_o,
   input  logic [31:0]      imem_data_i,
   output logic [31:0]      ifid_pc4_o,
   output logic [31:0]      ifid_inst_o,
   output logic             ifid_valid_o,
   output logic [CNT_W-1:0] fetch_cnt_o,
   output logic             running_o
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t state_q, state_d;
   logic [31:0] pc_q, pc_d, pc4_q, pc4_d, inst_q, inst_d, pc_plus4, target;
   logic valid_q, valid_d, run, redirect, flush, advance;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   assign run      = state_q == RUN;
   assign redirect = jump_i | branch_taken_i;
   assign flush    = run & redirect;
   assign advance  = run & ~redirect & ~stall_i;
   assign pc_plus4 = pc_q + 32'd4;
   // jump outranks branch; targets are word-aligned before loading
   assign target   = {(jump_i ? jump_addr_i[31:2] : branch_addr_i[31:2]), 2'b00};
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         pc4_q   <= 32'd0;
         inst_q  <= NOP_INST;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pc4_q   <= pc4_d;
         inst_q  <= inst_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end
   always_comb begin
      state_d = (state_q == IDLE && start_i) ? RUN : state_q;
   end
   always_comb begin
      pc_d    = flush ? target : advance ? pc_plus4 : pc_q;
      pc4_d   = flush ? 32'd0 : advance ? pc_plus4 : pc4_q;
      inst_d  = flush ? NOP_INST : advance ? imem_data_i : inst_q;
      valid_d = flush ? 1'b0 : advance ? 1'b1 : valid_q;
      cnt_d   = advance ? cnt_q + CNT_W'(1) : cnt_q;
   end
   assign imem_addr_o  = pc_q;
   assign ifid_pc4_o   = pc4_q;
   assign ifid_inst_o  = inst_q;
   assign ifid_valid_o = valid_q;
   assign fetch_cnt_o  = cnt_q;
   assign running_o    = run;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed checks of if_stage fetch, stall, redirect, wrap and reset behaviour.
module tb_if_stage;
   logic clk = 1'b0, rst = 1'b0, start = 1'b0, stall = 1'b0, br = 1'b0, jmp = 1'b0;
   logic [31:0] br_addr = 32'd0, jmp_addr = 32'd0, imem_addr, imem_data, pc4, inst;
   logic valid, running;
   logic [31:0] cnt;
   int errors = 0, checks = 0;
   always #5 clk = ~clk;
   // instruction memory returns an address-tagged word
   assign imem_data = imem_addr | 32'hA000_0000;
   if_stage dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall),
      .branch_taken_i(br), .branch_addr_i(br_addr), .jump_i(jmp), .jump_addr_i(jmp_addr),
      .imem_addr_o(imem_addr), .imem_data_i(imem_data), .ifid_pc4_o(pc4), .ifid_inst_o(inst),
      .ifid_valid_o(valid), .fetch_cnt_o(cnt), .running_o(running)
   );
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic expect_state(input string name, input logic [31:0] e_addr, input logic [31:0] e_pc4,
                               input logic [31:0] e_inst, input logic e_valid, input logic [31:0] e_cnt,
                               input logic e_run);
      checks++;
      if (imem_addr !== e_addr || pc4 !== e_pc4 || inst !== e_inst || valid !== e_valid ||
          cnt !== e_cnt || running !== e_run) begin
         errors++;
         $display("FAIL %s: got addr=%h pc4=%h inst=%h valid=%b cnt=%0d run=%b, want addr=%h pc4=%h inst=%h valid=%b cnt=%0d run=%b",
                  name, imem_addr, pc4, inst, valid, cnt, running, e_addr, e_pc4, e_inst, e_valid, e_cnt, e_run);
      end
   endtask
   task automatic test_reset();
      rst = 1'b1; stall = 1'b1; jmp = 1'b1; jmp_addr = 32'h50;
      step();
      expect_state("reset", 32'h0, 32'h0, 32'h0, 1'b0, 0, 1'b0);
      rst = 1'b0;
      step();
      expect_state("idle_ignores_redirect", 32'h0, 32'h0, 32'h0, 1'b0, 0, 1'b0);
      stall = 1'b0; jmp = 1'b0;
   endtask
   task automatic test_fetch();
      start = 1'b1;
      step();
      expect_state("start", 32'h0, 32'h0, 32'h0, 1'b0, 0, 1'b1);
      start = 1'b0;
      step();
      expect_state("fetch1", 32'h4, 32'h4, 32'hA000_0000, 1'b1, 1, 1'b1);
      step();
      expect_state("fetch2", 32'h8, 32'h8, 32'hA000_0004, 1'b1, 2, 1'b1);
      step();
      expect_state("fetch3", 32'hC, 32'hC, 32'hA000_0008, 1'b1, 3, 1'b1);
      step();
      expect_state("fetch4", 32'h10, 32'h10, 32'hA000_000C, 1'b1, 4, 1'b1);
   endtask
   task automatic test_stall();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         expect_state("stall_hold", 32'h10, 32'h10, 32'hA000_000C, 1'b1, 4, 1'b1);
      end
      stall = 1'b0;
      step();
      expect_state("stall_release", 32'h14, 32'h14, 32'hA000_0010, 1'b1, 5, 1'b1);
   endtask
   task automatic test_branch();
      br = 1'b1; br_addr = 32'h42;
      step();
      expect_state("branch_flush", 32'h40, 32'h0, 32'h0, 1'b0, 5, 1'b1);
      br = 1'b0;
      step();
      expect_state("branch_target", 32'h44, 32'h44, 32'hA000_0040, 1'b1, 6, 1'b1);
   endtask
   task automatic test_back_to_back();
      jmp = 1'b1; jmp_addr = 32'h103; br = 1'b1; br_addr = 32'h80; stall = 1'b1;
      step();
      expect_state("jump_wins", 32'h100, 32'h0, 32'h0, 1'b0, 6, 1'b1);
      jmp = 1'b0;
      step();
      expect_state("branch_over_stall", 32'h80, 32'h0, 32'h0, 1'b0, 6, 1'b1);
      br = 1'b0;
      step();
      expect_state("stall_after_flush", 32'h80, 32'h0, 32'h0, 1'b0, 6, 1'b1);
      stall = 1'b0;
      step();
      expect_state("resume_after_flush", 32'h84, 32'h84, 32'hA000_0080, 1'b1, 7, 1'b1);
   endtask
   task automatic test_wrap();
      jmp = 1'b1; jmp_addr = 32'hFFFF_FFFF;
      step();
      expect_state("jump_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 7, 1'b1);
      jmp = 1'b0;
      step();
      expect_state("wrap", 32'h0, 32'h0, 32'hFFFF_FFFC, 1'b1, 8, 1'b1);
   endtask
   task automatic test_mid_reset();
      jmp = 1'b1; jmp_addr = 32'h24;
      step();
      jmp = 1'b0; stall = 1'b1; rst = 1'b1;
      step();
      expect_state("mid_reset", 32'h0, 32'h0, 32'h0, 1'b0, 0, 1'b0);
      rst = 1'b0; stall = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         expect_state("idle_hold", 32'h0, 32'h0, 32'h0, 1'b0, 0, 1'b0);
      end
      start = 1'b1;
      step();
      start = 1'b0;
      expect_state("restart", 32'h0, 32'h0, 32'h0, 1'b0, 0, 1'b1);
      step();
      expect_state("restart_fetch", 32'h4, 32'h4, 32'hA000_0000, 1'b1, 1, 1'b1);
   endtask
   initial begin
      test_reset();
      test_fetch();
      test_stall();
      test_branch();
      test_back_to_back();
      test_wrap();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
